// File: rtl/ray_pkg.sv
// Shared types and constants for the ray traverser.
package ray_pkg;

    localparam int WIDTH         = 16;
    localparam int MATERIAL_BITS = 8;

    // Three coordinate components, element [i] is one WIDTH-bit component.
    typedef logic [2:0][WIDTH-1:0] vec3_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        START,
        WAIT,
        RESULT
    } traverser_state_t;

endpackage

// File: rtl/ray_traverser.sv
// Marches one ray through a voxel space: look up the voxel at the current
// point, step across it if empty, repeat until hit, exit or budget exhausted.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a ray from the generator
// LOOKUP | voxel lookup outstanding for point q
// START  | one-cycle stepper start with q, v and the voxel AABB
// WAIT   | stepper busy; AABB held until stepDone
// RESULT | result offered downstream, fields frozen
module ray_traverser
    import ray_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_STEPS = 64,
    parameter int STEP_BITS = 7
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rayValid,
    output logic                          rayReady,
    input  logic [2:0][WIDTH-1:0]         rayQ,
    input  logic [2:0][WIDTH-1:0]         rayV,
    output logic                          lookupReq,
    output logic [2:0][WIDTH-1:0]         lookupPoint,
    input  logic                          lookupAck,
    input  logic                          lookupOccupied,
    input  logic [MATERIAL_BITS-1:0]      lookupMaterial,
    input  logic [2:0][WIDTH-1:0]         lookupL,
    input  logic [2:0][WIDTH-1:0]         lookupU,
    output logic                          stepStart,
    output logic [2:0][WIDTH-1:0]         stepQ,
    output logic [2:0][WIDTH-1:0]         stepV,
    output logic [2:0][WIDTH-1:0]         stepL,
    output logic [2:0][WIDTH-1:0]         stepU,
    input  logic                          stepDone,
    input  logic                          stepOutOfBounds,
    input  logic [2:0][WIDTH-1:0]         stepVp,
    output logic                          resultValid,
    input  logic                          resultReady,
    output logic                          resultHit,
    output logic                          resultTimeout,
    output logic [2:0][WIDTH-1:0]         resultPoint,
    output logic [MATERIAL_BITS-1:0]      resultMaterial,
    output logic [STEP_BITS-1:0]          resultSteps
);

    traverser_state_t             state;
    logic [2:0][WIDTH-1:0]        q;
    logic [2:0][WIDTH-1:0]        v;
    logic [2:0][WIDTH-1:0]        l;
    logic [2:0][WIDTH-1:0]        u;
    logic [STEP_BITS-1:0]         count;
    logic                         hit;
    logic                         timeout;
    logic [MATERIAL_BITS-1:0]     material;

    // q always holds the final point once RESULT is reached (the hit voxel
    // point, the exit point, or the stalled point), so the datapath
    // registers drive the outputs directly.
    assign lookupPoint    = q;
    assign stepQ          = q;
    assign stepV          = v;
    assign stepL          = l;
    assign stepU          = u;
    assign resultHit      = hit;
    assign resultTimeout  = timeout;
    assign resultPoint    = q;
    assign resultMaterial = material;
    assign resultSteps    = count;

    // Traversal FSM with registered handshake outputs and datapath updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rayReady    <= 1'b1;
            lookupReq   <= 1'b0;
            stepStart   <= 1'b0;
            resultValid <= 1'b0;
            q           <= '0;
            v           <= '0;
            l           <= '0;
            u           <= '0;
            count       <= '0;
            hit         <= 1'b0;
            timeout     <= 1'b0;
            material    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rayValid) begin
                        q         <= rayQ;
                        v         <= rayV;
                        count     <= '0;
                        hit       <= 1'b0;
                        timeout   <= 1'b0;
                        material  <= '0;
                        rayReady  <= 1'b0;
                        lookupReq <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookupAck) begin
                        lookupReq <= 1'b0;
                        if (lookupOccupied) begin
                            hit         <= 1'b1;
                            material    <= lookupMaterial;
                            resultValid <= 1'b1;
                            state       <= RESULT;
                        end else begin
                            l         <= lookupL;
                            u         <= lookupU;
                            stepStart <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    stepStart <= 1'b0;
                    count     <= count + STEP_BITS'(1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (stepDone) begin
                        if (stepOutOfBounds) begin
                            q           <= stepVp;
                            resultValid <= 1'b1;
                            state       <= RESULT;
                        end else if (stepVp == q) begin
                            // A stalled stepper would loop forever; report it as a timeout.
                            timeout     <= 1'b1;
                            resultValid <= 1'b1;
                            state       <= RESULT;
                        end else if (count == STEP_BITS'(MAX_STEPS)) begin
                            timeout     <= 1'b1;
                            q           <= stepVp;
                            resultValid <= 1'b1;
                            state       <= RESULT;
                        end else begin
                            q         <= stepVp;
                            lookupReq <= 1'b1;
                            state     <= LOOKUP;
                        end
                    end
                end
                RESULT: begin
                    if (resultReady) begin
                        resultValid <= 1'b0;
                        rayReady    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_traverser.sv
// Directed bench for ray_traverser with lookup and stepper models and a
// result scoreboard.
module tb_ray_traverser;
    import ray_pkg::*;

    localparam int W  = 16;
    localparam int MS = 4;
    localparam int SB = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        rayValid;
    logic        rayReady;
    vec3_t       rayQ, rayV;
    logic        lookupReq;
    vec3_t       lookupPoint;
    logic        lookupAck;
    logic        lookupOccupied;
    logic [7:0]  lookupMaterial;
    vec3_t       lookupL, lookupU;
    logic        stepStart;
    vec3_t       stepQ, stepV, stepL, stepU;
    logic        stepDone;
    logic        stepOutOfBounds;
    vec3_t       stepVp;
    logic        resultValid;
    logic        resultReady;
    logic        resultHit;
    logic        resultTimeout;
    vec3_t       resultPoint;
    logic [7:0]  resultMaterial;
    logic [SB-1:0] resultSteps;

    ray_traverser #(.WIDTH(W), .MAX_STEPS(MS), .STEP_BITS(SB)) dut (
        .clock(clock), .reset(reset),
        .rayValid(rayValid), .rayReady(rayReady), .rayQ(rayQ), .rayV(rayV),
        .lookupReq(lookupReq), .lookupPoint(lookupPoint), .lookupAck(lookupAck),
        .lookupOccupied(lookupOccupied), .lookupMaterial(lookupMaterial),
        .lookupL(lookupL), .lookupU(lookupU),
        .stepStart(stepStart), .stepQ(stepQ), .stepV(stepV), .stepL(stepL), .stepU(stepU),
        .stepDone(stepDone), .stepOutOfBounds(stepOutOfBounds), .stepVp(stepVp),
        .resultValid(resultValid), .resultReady(resultReady), .resultHit(resultHit),
        .resultTimeout(resultTimeout), .resultPoint(resultPoint),
        .resultMaterial(resultMaterial), .resultSteps(resultSteps)
    );

    always #5 clock = ~clock;

    typedef struct { logic hit; logic tmo; vec3_t pt; logic [7:0] mat; logic [SB-1:0] steps; } exp_t;
    typedef struct { logic occ; logic [7:0] mat; vec3_t l; vec3_t u; } lk_t;
    typedef struct { logic oob; logic same; vec3_t vp; int dly; } st_t;

    exp_t sb[$];
    lk_t  lk_q[$];
    st_t  st_q[$];

    int    checks   = 0;
    int    failures = 0;
    int    starts   = 0;
    vec3_t last_l = '0, last_u = '0;
    logic  abandon = 1'b0;
    logic  late_done = 1'b0;

    function automatic vec3_t mk(input int x, input int y, input int z);
        vec3_t r;
        r[0] = W'(x); r[1] = W'(y); r[2] = W'(z);
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lookup model: answers each request with the next scripted voxel.
    initial begin
        lookupAck = 0; lookupOccupied = 0; lookupMaterial = 0; lookupL = '0; lookupU = '0;
        forever begin
            lk_t e;
            @(negedge clock);
            lookupAck = 0;
            if (lookupReq && lk_q.size() > 0) begin
                e = lk_q.pop_front();
                lookupOccupied = e.occ;
                lookupMaterial = e.mat;
                lookupL = e.l;
                lookupU = e.u;
                last_l = e.l;
                last_u = e.u;
                lookupAck = 1;
            end
        end
    end

    // Stepper model: after a start, returns the next scripted exit point.
    initial begin
        st_t   e;
        vec3_t cq;
        int    cnt;
        logic  pend;
        pend = 0; cnt = 0; cq = '0;
        stepDone = 0; stepOutOfBounds = 0; stepVp = '0;
        forever begin
            @(negedge clock);
            stepDone = 0;
            if (stepStart) begin
                starts++;
                cmp("start_l", 64'(stepL), 64'(last_l));
                cmp("start_u", 64'(stepU), 64'(last_u));
                if (st_q.size() > 0) begin
                    e = st_q.pop_front();
                    cq = stepQ;
                    cnt = e.dly;
                    pend = 1;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    if (!abandon) cmp("wait_l_held", 64'(stepL), 64'(last_l));
                    else late_done = 1;
                    stepOutOfBounds = e.oob;
                    stepVp = e.same ? cq : e.vp;
                    stepDone = 1;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic send_ray(input vec3_t q0, input vec3_t v0);
        @(negedge clock);
        rayValid = 1; rayQ = q0; rayV = v0;
        @(negedge clock);
        rayValid = 0;
    endtask

    task automatic wait_result(input string tag, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!resultValid && n < 300) begin
            @(negedge clock);
            n++;
        end
        cmp({tag, "_valid"}, 64'(resultValid), 64'(1));
        if (resultValid) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL %s_unexpected observed=result expected=none", tag);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({tag, "_hit"},   64'(resultHit),      64'(e.hit));
                cmp({tag, "_tmo"},   64'(resultTimeout),  64'(e.tmo));
                cmp({tag, "_point"}, 64'(resultPoint),    64'(e.pt));
                cmp({tag, "_mat"},   64'(resultMaterial), 64'(e.mat));
                cmp({tag, "_steps"}, 64'(resultSteps),    64'(e.steps));
                for (int i = 0; i < hold; i++) begin
                    @(negedge clock);
                    cmp({tag, "_hold_valid"}, 64'(resultValid), 64'(1));
                    cmp({tag, "_hold_point"}, 64'(resultPoint), 64'(e.pt));
                    cmp({tag, "_hold_fields"}, 64'({resultHit, resultTimeout, resultMaterial, resultSteps}),
                        64'({e.hit, e.tmo, e.mat, e.steps}));
                    cmp({tag, "_hold_rayready"}, 64'(rayReady), 64'(0));
                end
            end
            resultReady = 1;
            @(negedge clock);
            resultReady = 0;
            cmp({tag, "_ready_after"}, 64'(rayReady), 64'(1));
            cmp({tag, "_valid_drop"}, 64'(resultValid), 64'(0));
        end
    endtask

    initial begin
        int s0, lat, n;
        reset = 1; rayValid = 0; rayQ = '0; rayV = '0; resultReady = 0;
        repeat (2) @(negedge clock);
        cmp("rst_rayready", 64'(rayReady), 64'(1));
        cmp("rst_lookupreq", 64'(lookupReq), 64'(0));
        cmp("rst_stepstart", 64'(stepStart), 64'(0));
        cmp("rst_resultvalid", 64'(resultValid), 64'(0));
        cmp("rst_point", 64'(resultPoint), 64'(0));
        cmp("rst_steps", 64'(resultSteps), 64'(0));
        reset = 0;

        // Immediate hit: latency and no stepper use.
        lk_q.push_back('{1'b1, 8'd5, mk(0,0,0), mk(8,8,8)});
        sb.push_back('{1'b1, 1'b0, mk(4,4,4), 8'd5, SB'(0)});
        s0 = starts;
        @(negedge clock);
        rayValid = 1; rayQ = mk(4,4,4); rayV = mk(1,0,0);
        @(negedge clock);
        rayValid = 0;
        lat = 1;
        while (!resultValid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        cmp("hit_latency", 64'(lat), 64'(2));
        wait_result("imm_hit", 0);
        cmp("imm_hit_starts", 64'(starts - s0), 64'(0));

        // Three empty voxels then a hit.
        for (int i = 0; i < 3; i++)
            lk_q.push_back('{1'b0, 8'd0, mk(8*i,0,0), mk(8*i+8,8,8)});
        lk_q.push_back('{1'b1, 8'd9, mk(24,0,0), mk(32,8,8)});
        st_q.push_back('{1'b0, 1'b0, mk(8,4,4), 1});
        st_q.push_back('{1'b0, 1'b0, mk(16,4,4), 2});
        st_q.push_back('{1'b0, 1'b0, mk(24,4,4), 0});
        sb.push_back('{1'b1, 1'b0, mk(24,4,4), 8'd9, SB'(3)});
        s0 = starts;
        send_ray(mk(4,4,4), mk(1,0,0));
        wait_result("march_hit", 0);
        cmp("march_hit_starts", 64'(starts - s0), 64'(3));

        // Leaves the scene.
        lk_q.push_back('{1'b0, 8'd0, mk(0,0,0), mk(8,8,8)});
        st_q.push_back('{1'b1, 1'b0, mk(255,4,4), 1});
        sb.push_back('{1'b0, 1'b0, mk(255,4,4), 8'd0, SB'(1)});
        send_ray(mk(4,4,4), mk(1,0,0));
        wait_result("oob", 0);

        // Step budget exhausted while always progressing.
        for (int i = 0; i < MS; i++) begin
            lk_q.push_back('{1'b0, 8'd0, mk(8*i,0,0), mk(8*i+8,8,8)});
            st_q.push_back('{1'b0, 1'b0, mk(8*i+8,4,4), 1});
        end
        sb.push_back('{1'b0, 1'b1, mk(8*MS,4,4), 8'd0, SB'(MS)});
        send_ray(mk(4,4,4), mk(1,0,0));
        wait_result("budget", 0);
        cmp("budget_lookups_left", 64'(lk_q.size()), 64'(0));

        // Stepper makes no progress.
        lk_q.push_back('{1'b0, 8'd0, mk(0,0,0), mk(8,8,8)});
        st_q.push_back('{1'b0, 1'b1, mk(0,0,0), 1});
        sb.push_back('{1'b0, 1'b1, mk(1,2,3), 8'd0, SB'(1)});
        send_ray(mk(1,2,3), mk(0,1,0));
        wait_result("stall", 0);

        // Reset during WAIT, then a late stepDone.
        lk_q.push_back('{1'b0, 8'd0, mk(0,0,0), mk(8,8,8)});
        st_q.push_back('{1'b0, 1'b0, mk(8,4,4), 5});
        s0 = starts;
        send_ray(mk(4,4,4), mk(1,0,0));
        n = 0;
        while (starts == s0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        cmp("rst_mid_started", 64'(starts - s0), 64'(1));
        @(negedge clock);
        abandon = 1;
        reset = 1;
        @(negedge clock);
        reset = 0;
        cmp("rst_mid_rayready", 64'(rayReady), 64'(1));
        cmp("rst_mid_lookupreq", 64'(lookupReq), 64'(0));
        cmp("rst_mid_valid", 64'(resultValid), 64'(0));
        cmp("rst_mid_steps", 64'(resultSteps), 64'(0));
        cmp("rst_mid_stepl", 64'(stepL), 64'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            cmp("rst_mid_no_result", 64'(resultValid), 64'(0));
            cmp("rst_mid_idle", 64'(rayReady), 64'(1));
        end
        cmp("rst_mid_late_done", 64'(late_done), 64'(1));
        abandon = 0;

        // Next ray processed normally, result held for 10 cycles.
        lk_q.push_back('{1'b1, 8'd7, mk(0,0,0), mk(8,8,8)});
        sb.push_back('{1'b1, 1'b0, mk(2,3,4), 8'd7, SB'(0)});
        send_ray(mk(2,3,4), mk(1,1,1));
        wait_result("hold", 10);

        cmp("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
